// File: rtl/stream_demux_1x2_pkg.sv
// Shared definitions for the memory-bus return path.
//
// The select encoding below is the one the bus-side 2:1 muxes use when they
// merge the fetch and data requesters, so a response steered by
// stream_demux_1x2 lands back at the requester that issued it.
//   SEL_OUT0 : fetch side (out0)
//   SEL_OUT1 : data side  (out1)
package stream_demux_1x2_pkg;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    localparam int NUM_OUTPUTS = 2;

    // Maps an output index to its select encoding.
    function automatic logic sel_of_output(input int idx);
        return (idx == 0) ? SEL_OUT0 : SEL_OUT1;
    endfunction

endpackage

// File: rtl/stream_demux_1x2_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata this edge (ignored when full)
//   wdata  in   WIDTH payload
//   pop    in   remove head this edge (ignored when empty)
//   rdata  out  head entry, forced to 0 while empty
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy, 0..DEPTH
//
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Full/empty derive from the count rather than a pointer compare, which
// keeps the pointers exactly log2(DEPTH) bits wide.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are never visible because the
    // head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: routes one valid/ready stream to one of two outputs.
//
// Sits on the return path of the shared memory bus and hands each response
// back to its owner: in_sel=0 -> out0 (fetch), in_sel=1 -> out1 (data).
// Each output is buffered by its own sync_fifo so a stalled consumer only
// blocks beats headed for its own side.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready/in_sel/in_data    input stream and destination select
//   out0_valid/out0_ready/out0_data     fetch-side output stream
//   out1_valid/out1_ready/out1_data     data-side output stream
//   out0_count/out1_count         per-output FIFO occupancy
module stream_demux_1x2
    import stream_demux_1x2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic [$clog2(DEPTH+1)-1:0] out0_count,
    output logic [$clog2(DEPTH+1)-1:0] out1_count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_OUTPUTS-1:0] fifo_push;
    logic [NUM_OUTPUTS-1:0] fifo_pop;
    logic [NUM_OUTPUTS-1:0] fifo_full;
    logic [NUM_OUTPUTS-1:0] fifo_empty;
    logic [NUM_OUTPUTS-1:0] out_ready;
    logic [WIDTH-1:0]       fifo_rdata [NUM_OUTPUTS];
    logic [CW-1:0]          fifo_count [NUM_OUTPUTS];

    logic target_full;
    logic in_fire;

    // in_ready only looks at registered FIFO state and in_sel; a pop in the
    // same cycle does not open the input, which keeps out*_ready off the
    // in_ready path.
    assign target_full = (in_sel == SEL_OUT1) ? fifo_full[1] : fifo_full[0];
    assign in_ready    = !reset && !target_full;
    // Gating by in_valid first keeps an undriven in_sel on idle cycles
    // from reaching either FIFO's push.
    assign in_fire     = in_valid && in_ready;

    assign out_ready = {out1_ready, out0_ready};

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
        assign fifo_push[gi] = in_fire && (in_sel == sel_of_output(gi));
        assign fifo_pop[gi]  = out_ready[gi] && !fifo_empty[gi];

        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[gi]),
            .wdata (in_data),
            .pop   (fifo_pop[gi]),
            .rdata (fifo_rdata[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi]),
            .count (fifo_count[gi])
        );
    end

    assign out0_valid = !fifo_empty[0];
    assign out0_data  = fifo_rdata[0];
    assign out0_count = fifo_count[0];
    assign out1_valid = !fifo_empty[1];
    assign out1_data  = fifo_rdata[1];
    assign out1_count = fifo_count[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Testbench for stream_demux_1x2: directed scenarios followed by random
// traffic, checked by a queue-based reference model.
module tb_stream_demux_1x2;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 2;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int TIMEOUT = 50;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid, out1_valid;
    logic             out0_ready, out1_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [CW-1:0]    out0_count, out1_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    int max_cnt0 = 0;

    // Reference model: one queue of expected beats per output.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    stream_demux_1x2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, between the drive
    // point (posedge+1) and the next active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int  n0, n1;
            logic exp_rdy;
            n0 = q0.size();
            n1 = q1.size();
            if (n0 > max_cnt0) max_cnt0 = n0;
            exp_rdy = !reset && ((in_sel ? n1 : n0) < DEPTH);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out0_valid", 32'(out0_valid), 32'(n0 != 0));
            chk("out1_valid", 32'(out1_valid), 32'(n1 != 0));
            chk("out0_count", 32'(out0_count), 32'(n0));
            chk("out1_count", 32'(out1_count), 32'(n1));
            chk("out0_data", out0_data, (n0 != 0) ? q0[0] : 32'h0);
            chk("out1_data", out1_data, (n1 != 0) ? q1[0] : 32'h0);
            if (n0 != 0 && out0_ready) begin
                $display("out0 beat %h", q0[0]);
                void'(q0.pop_front());
            end
            if (n1 != 0 && out1_ready) begin
                $display("out1 beat %h", q1[0]);
                void'(q1.pop_front());
            end
            if (reset) begin
                q0.delete();
                q1.delete();
            end else if (in_valid && exp_rdy) begin
                $display("in  sel=%0d beat %h", in_sel, in_data);
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Presents one beat and holds it until accepted.
    task automatic send(input logic sel, input logic [WIDTH-1:0] data);
        in_valid = 1;
        in_sel   = sel;
        in_data  = data;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", data);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0;
        reset = 1; in_valid = 0; in_sel = 0; in_data = '0;
        out0_ready = 0; out1_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        idle(1);
        reset = 0;
        in_sel = 0;
        idle(1);

        // Routing
        out0_ready = 1; out1_ready = 1;
        send(0, 32'hDEADBEEF);
        send(1, 32'hCAFEBABE);
        idle(3);

        // Backpressure / full
        out0_ready = 0;
        send(0, 32'd1);
        send(0, 32'd2);
        in_valid = 1; in_sel = 0; in_data = 32'd3;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(out0_count), 32'd2);
        @(posedge clk); #1;
        send(1, 32'hA5A5A5A5);
        idle(2);
        out0_ready = 1;
        idle(4);

        // Full-throughput stream on out0
        max_cnt0 = 0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(0, 32'(i));
        chk("stream_cycles", 32'(cyc - t0), 32'd8);
        idle(3);
        chk("stream_max_count", 32'(max_cnt0), 32'd1);

        // Wrap-around on out1
        for (int r = 0; r < 5; r++) begin
            out1_ready = 0;
            for (int k = 0; k < DEPTH; k++) send(1, 32'h100 * (r + 1) + 32'(k));
            out1_ready = 1;
            idle(DEPTH + 1);
        end
        chk("wrap_count", 32'(out1_count), 32'd0);

        // Reset mid-operation
        out0_ready = 0; out1_ready = 0;
        send(0, 32'h00000AA0);
        send(0, 32'h00000AA1);
        send(1, 32'h00000BB0);
        reset = 1;
        idle(1);
        reset = 0;
        @(negedge clk);
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_count", 32'(out1_count), 32'd0);
        @(posedge clk); #1;
        out1_ready = 1;
        send(1, 32'h12345678);
        @(negedge clk);
        chk("post_rst_beat", out1_data, 32'h12345678);
        @(posedge clk); #1;
        idle(2);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            in_valid   = 1'($urandom % 2);
            in_sel     = 1'($urandom % 2);
            in_data    = $urandom;
            out0_ready = ($urandom % 10) < 7;
            out1_ready = ($urandom % 10) < 5;
            reset      = ($urandom % 100) == 0;
            idle(1);
        end

        in_valid = 0; reset = 0; out0_ready = 1; out1_ready = 1;
        idle(DEPTH + 3);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
